// File: rtl/tlb_walker.sv
// tlb_walker: single-level hardware page-table walker sitting behind the TLB.
// A qualified miss triggers one PTE read at ptbr + VPN*4. A valid PTE is
// written back through the TLB refill port, and an invalid one raises a
// one-cycle page fault.
// Optional build macro PTW_TIMEOUT_EN adds a memory-ack watchdog of
// TIMEOUT_CYCLES request cycles, plus a timeout_o pulse that accompanies
// the resulting fault.
//
// state   | meaning
// S_IDLE  | waiting for a qualified miss; mem_ack_i ignored
// S_REQ   | PTE read outstanding, mem_req_o high, mem_addr_o held
// S_FILL  | one-cycle TLB write strobe with latched VPN/PPN
// S_FAULT | one-cycle page-fault pulse, fault_vaddr_o updated
module tlb_walker #(
    parameter int OFFSET         = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tlb_miss_i,
    input  logic               access_valid_i,
    input  logic [31:0]        virtual_address_i,
    input  logic [31:0]        ptbr_i,
    input  logic               flush_i,
    output logic               mem_req_o,
    output logic [31:0]        mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [31:0]        mem_rdata_i,
    output logic [31-OFFSET:0] w_virtual_page_o,
    output logic [31-OFFSET:0] w_phys_page_o,
    output logic               write_enable_o,
    output logic               busy_o,
    output logic               page_fault_o,
    output logic [31:0]        fault_vaddr_o
`ifdef PTW_TIMEOUT_EN
    ,
    output logic               timeout_o
`endif
);

    localparam int VPN_W = 32 - OFFSET;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_FILL  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_fill;
    logic             w_fault;
    logic [VPN_W-1:0] r_vpn;
    logic [VPN_W-1:0] r_ppn;
    logic [31:0]      r_vaddr;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_fault_vaddr;

    // Only the valid bit and the PPN field of the PTE carry meaning.
    logic w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata_i[OFFSET-1:1];

`ifdef PTW_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic             w_timeout_hit;
    logic             w_tmo_fault;

    // The current REQ cycle is the last one allowed without an ack.
    assign w_timeout_hit = (r_state == S_REQ) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Priority in REQ is flush, then ack, then watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fill      = 1'b0;
        w_fault     = 1'b0;
`ifdef PTW_TIMEOUT_EN
        w_tmo_fault = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (tlb_miss_i && access_valid_i && !flush_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (mem_ack_i) begin
                    if (mem_rdata_i[0]) begin
                        w_fill      = 1'b1;
                        w_state_nxt = S_FILL;
                    end else begin
                        w_fault     = 1'b1;
                        w_state_nxt = S_FAULT;
                    end
                end
`ifdef PTW_TIMEOUT_EN
                else if (w_timeout_hit) begin
                    w_fault     = 1'b1;
                    w_tmo_fault = 1'b1;
                    w_state_nxt = S_FAULT;
                end
`endif
            end
            S_FILL, S_FAULT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Walk context: the PTE address is captured once at acceptance, so
    // later ptbr_i/virtual_address_i changes cannot disturb the request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_vpn         <= '0;
            r_ppn         <= '0;
            r_vaddr       <= '0;
            r_mem_addr    <= '0;
            r_fault_vaddr <= '0;
        end else begin
            if (w_accept) begin
                r_vpn      <= virtual_address_i[31:OFFSET];
                r_vaddr    <= virtual_address_i;
                r_mem_addr <= ptbr_i + 32'({virtual_address_i[31:OFFSET], 2'b00});
            end
            if (w_fill) begin
                r_ppn <= mem_rdata_i[31:OFFSET];
            end
            if (w_fault) begin
                r_fault_vaddr <= r_vaddr;
            end
        end
    end

`ifdef PTW_TIMEOUT_EN
    // Watchdog: zero whenever not waiting, so each walk starts fresh.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != S_REQ) begin
                r_cnt <= '0;
            end else if (!mem_ack_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_timeout <= w_tmo_fault;
        end
    end

    assign timeout_o = r_timeout;
`endif

    assign mem_req_o        = (r_state == S_REQ);
    assign mem_addr_o       = r_mem_addr;
    assign write_enable_o   = (r_state == S_FILL);
    assign page_fault_o     = (r_state == S_FAULT);
    assign busy_o           = (r_state != S_IDLE);
    assign w_virtual_page_o = r_vpn;
    assign w_phys_page_o    = r_ppn;
    assign fault_vaddr_o    = r_fault_vaddr;

endmodule

// File: doc/tlb_walker.md
Name: tlb_walker

Overview:
- Hardware page-table walker directly downstream of the TLB. It consumes the TLB's miss indication and drives the TLB's refill write port.
- On a miss, it fetches one page-table entry (PTE) from a flat, single-level page table in memory.
- A valid PTE is written into the TLB. An invalid PTE produces a page fault.
- The pipeline stalls on busy_o while a walk is in flight.

Parameters:
- OFFSET, 12: page-offset bits. Virtual page number (VPN) width = 32-OFFSET.
- TIMEOUT_CYCLES, 255: memory-ack watchdog limit, in cycles. Used only with PTW_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- tlb_miss_i  in  1  miss flag from TLB (combinational)
- access_valid_i  in  1  current virtual address is a real access; qualifies tlb_miss_i
- virtual_address_i  in  32  address that missed
- ptbr_i  in  32  page-table base byte address
- flush_i  in  1  abort any walk, no TLB write
- mem_req_o  out  1  PTE read request
- mem_addr_o  out  32  PTE byte address
- mem_ack_i  in  1  read complete; mem_rdata_i valid this cycle
- mem_rdata_i  in  32  PTE. Bit 0 = valid; bits [31:OFFSET] = physical page number (PPN)
- w_virtual_page_o  out  32-OFFSET  TLB write VPN
- w_phys_page_o  out  32-OFFSET  TLB write PPN
- write_enable_o  out  1  TLB write strobe
- busy_o  out  1  walk in progress; pipeline stalls
- page_fault_o  out  1  fault pulse
- fault_vaddr_o  out  32  address that faulted

Behaviour:
- States: IDLE, REQ, FILL, FAULT.
- Reset (sync, highest priority): state=IDLE. All outputs are 0, including fault_vaddr_o and the latched VPN/PPN. Reset mid-walk drops mem_req_o the next cycle and performs no TLB write. A late mem_ack_i after reset is ignored.
- IDLE:
  - If tlb_miss_i && access_valid_i && !flush_i: latch VPN = virtual_address_i[31:OFFSET], latch the full address, go to REQ.
  - mem_ack_i is ignored in IDLE.
- REQ:
  - mem_req_o=1. mem_addr_o = ptbr_i + {VPN,2'b00}, computed mod 2^32 (wrap ignored).
  - mem_addr_o is registered at the IDLE->REQ edge and held stable until ack.
  - On mem_ack_i: if mem_rdata_i[0]=1, latch PPN = mem_rdata_i[31:OFFSET] and go to FILL; otherwise go to FAULT.
  - mem_req_o drops in the cycle after the ack.
- FILL:
  - write_enable_o=1 for exactly one cycle. w_virtual_page_o = latched VPN, w_phys_page_o = latched PPN.
  - Next state: IDLE.
- FAULT:
  - page_fault_o=1 for exactly one cycle. fault_vaddr_o = latched address; it holds until the next fault or reset.
  - No TLB write. Next state: IDLE.
- busy_o = (state != IDLE).
- Latency: miss sampled at edge 0; mem_req_o high from cycle 1. Ack in cycle k gives write_enable_o/page_fault_o in cycle k+1 and busy_o low in cycle k+2. Best case (k=1): refill occurs 2 cycles after the miss.
- A new miss is accepted only in IDLE. Back-to-back misses are accepted on the first IDLE cycle after FILL/FAULT. tlb_miss_i is ignored while busy.
- flush_i:
  - In any non-IDLE state: go to IDLE next cycle, with no write and no fault.
  - If flush_i coincides with mem_ack_i, flush wins.
  - If flush_i is high in the FILL cycle, the write still completes (it is already committed).
- Write-port outputs other than write_enable_o are don't-care when the strobe is 0. They hold their last latched values.

Optional Feature:
- Macro: PTW_TIMEOUT_EN.
- Defined:
  - An 8-bit or wider counter clears on entry to REQ and increments each REQ cycle without mem_ack_i.
  - When the counter reaches TIMEOUT_CYCLES, go to FAULT: page_fault_o pulses, mem_req_o drops, and the timeout_o output (1 bit, present only with the macro) pulses with it.
  - If ack and timeout occur in the same cycle, the ack wins.
- Undefined: no counter and no timeout_o. REQ waits indefinitely.

Test Plan (OFFSET=12):
- Refill: ptbr_i=0x0001_0000, miss on 0x0040_3ABC, ack after 3 cycles with 0x0008_7001 -> mem_addr_o=0x0001_100C; write_enable_o one cycle with VPN=0x00403, PPN=0x00087; busy_o low 2 cycles after ack.
- Fault: same walk, PTE=0x0008_7000 -> page_fault_o one-cycle pulse; fault_vaddr_o=0x0040_3ABC; write_enable_o never high.
- Flush/reset mid-walk: flush_i in REQ cycle 2, then ack one cycle later -> no write, no fault, busy_o low next cycle. Repeat with reset_i in place of flush_i -> all outputs 0.
- Back-to-back: miss 0x0000_1000 then miss 0x0000_2000 held during busy, ptbr_i=0 -> two walks at 0x0000_0004 then 0x0000_0008; second mem_req_o rises 1 cycle after first FILL/IDLE; no miss lost or duplicated.
- Wrap and ignore rules: ptbr_i=0xFFFF_FFF0, VPN=0x00005 -> mem_addr_o=0x0000_0004. Ack in IDLE -> no effect. Miss with access_valid_i=0 -> stays IDLE.
- PTW_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> page_fault_o and timeout_o pulse after 4 REQ cycles; mem_req_o low after. Ack coincident with limit -> normal fill.
